// File: rtl/keypad_scan.sv
// 4x3 matrix keypad scanner: rotating column drive, per-frame priority encode
// of closed keys, and a frame-rate debouncer producing a tone-generator key code.
module keypad_scan #(
  parameter int unsigned SCAN_DIV     = 1024,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] num,
  output logic       key_new
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_PEND = 2'd1,
    HELD       = 2'd2,
    REL_PEND   = 2'd3
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB      = 4'(DEBOUNCE_CNT);

  logic [3:0]  row_meta_q, row_sync_q;
  logic [15:0] div_q, div_d;
  logic [2:0]  col_q, col_d;
  logic [3:0]  acc_q, acc_d;
  state_t      state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic [3:0]  num_q, num_d;
  logic        key_new_q, key_new_d;

  logic        sample_s, frame_end_s;
  logic [1:0]  col_idx_s;
  logic [3:0]  cur_code_s, raw_s;

  // Bottom row is *,0,# rather than continuing the digit sequence.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    if (r == 2'd3) begin
      case (c)
        2'd0:    code = 4'd1;
        2'd1:    code = 4'd3;
        default: code = 4'd2;
      endcase
    end else begin
      code = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd4;
    end
    return code;
  endfunction

  function automatic logic [3:0] first_in_col(input logic [3:0] rv, input logic [1:0] c);
    logic [3:0] code;
    code = 4'd0;
    for (int r = 3; r >= 0; r--) begin
      if (rv[r]) code = key_code(2'(r), c);
    end
    return code;
  endfunction

  assign sample_s    = (div_q == DIV_LAST);
  assign frame_end_s = sample_s && col_q[2];
  assign col_idx_s   = col_q[0] ? 2'd0 : (col_q[1] ? 2'd1 : 2'd2);
  assign cur_code_s  = first_in_col(row_sync_q, col_idx_s);
  // Earlier columns win, so a code already captured this frame is kept.
  assign raw_s       = (acc_q != 4'd0) ? acc_q : cur_code_s;

  // Dwell counter, column rotation and per-frame code accumulation.
  always_comb begin
    div_d = div_q + 16'd1;
    col_d = col_q;
    acc_d = acc_q;
    if (sample_s) begin
      div_d = 16'd0;
      col_d = {col_q[1:0], col_q[2]};
      acc_d = col_q[0] ? cur_code_s : raw_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Debounce FSM, evaluated once per frame.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    dcnt_d    = dcnt_q;
    num_d     = num_q;
    key_new_d = 1'b0;
    if (frame_end_s) begin
      case (state_q)
        IDLE: begin
          if (raw_s != 4'd0) begin
            cand_d = raw_s;
            dcnt_d = 4'd1;
            if (DEB <= 4'd1) begin
              state_d   = HELD;
              num_d     = raw_s;
              key_new_d = 1'b1;
            end else begin
              state_d = PRESS_PEND;
            end
          end else begin
            state_d = IDLE;
          end
        end
        PRESS_PEND: begin
          if (raw_s == cand_q) begin
            dcnt_d = dcnt_q + 4'd1;
            if (dcnt_q + 4'd1 >= DEB) begin
              state_d   = HELD;
              num_d     = cand_q;
              key_new_d = 1'b1;
            end else begin
              state_d = PRESS_PEND;
            end
          end else if (raw_s == 4'd0) begin
            state_d = IDLE;
            dcnt_d  = 4'd0;
          end else begin
            cand_d = raw_s;
            dcnt_d = 4'd1;
          end
        end
        HELD: begin
          if (raw_s != num_q) begin
            dcnt_d = 4'd1;
            if (DEB <= 4'd1) begin
              state_d = IDLE;
              num_d   = 4'd0;
            end else begin
              state_d = REL_PEND;
            end
          end else begin
            state_d = HELD;
          end
        end
        REL_PEND: begin
          if (raw_s == num_q) begin
            state_d = HELD;
          end else begin
            dcnt_d = dcnt_q + 4'd1;
            if (dcnt_q + 4'd1 >= DEB) begin
              state_d = IDLE;
              num_d   = 4'd0;
            end else begin
              state_d = REL_PEND;
            end
          end
        end
        default: begin
          state_d = IDLE;
          num_d   = 4'd0;
          dcnt_d  = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers; reset also clears the synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= 4'd0;
      row_sync_q <= 4'd0;
      div_q      <= 16'd0;
      col_q      <= 3'b001;
      acc_q      <= 4'd0;
      state_q    <= IDLE;
      cand_q     <= 4'd0;
      dcnt_q     <= 4'd0;
      num_q      <= 4'd0;
      key_new_q  <= 1'b0;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      div_q      <= div_d;
      col_q      <= col_d;
      acc_q      <= acc_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      dcnt_q     <= dcnt_d;
      num_q      <= num_d;
      key_new_q  <= key_new_d;
    end
  end

  assign col     = col_q;
  assign num     = num_q;
  assign key_new = key_new_q;

endmodule
